// File: rtl/rng_share_arbiter.sv
// ============================================================================
//  Module   : rng_share_arbiter
//  Purpose  : One 8-bit maximal-length LFSR shared round-robin among N_REQ
//             stochastic-number requesters; the LFSR steps only when a word
//             is issued. Optional macro RNG_SHARE_DECORR_EN rotates each
//             issued word left by the requester index.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rng_share_arbiter #(
    parameter int         N_REQ        = 4,
    parameter int         WARMUP       = 16,
    parameter logic [7:0] DEFAULT_SEED = 8'hA5
) (
    input  logic             TRIG,
    input  logic             RESET,
    input  logic             LOAD,
    input  logic [7:0]       SEED,
    input  logic [N_REQ-1:0] REQ,
    output logic [N_REQ-1:0] GNT,
    output logic [7:0]       RND,
    output logic             VALID,
    output logic             READY
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [0:0] {
        ST_WARM = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [7:0]         rnd_q, rnd_d;
    logic               valid_q, valid_d;

    logic               found;
    logic [PW-1:0]      sel;
    logic [7:0]         word;

    // Fibonacci form of 1+x2+x3+x4+x8
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[3] ^ s[2] ^ s[1]};
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    // Round-robin search starting at the pointer, wrapping to 0
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!found && REQ[idx]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
    end

`ifdef RNG_SHARE_DECORR_EN
    assign word = rotl8(lfsr_q, 3'(sel));
`else
    assign word = lfsr_q;
`endif

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        rnd_d   = rnd_q;
        valid_d = 1'b0;

        if (LOAD) begin
            lfsr_d  = (SEED == 8'h00) ? DEFAULT_SEED : SEED;
            state_d = ST_WARM;
            cnt_d   = 8'h00;
            rnd_d   = 8'h00;
        end else begin
            case (state_q)
                ST_WARM: begin
                    if (WARMUP == 0) begin
                        state_d = ST_RUN;
                    end else begin
                        lfsr_d = lfsr_step(lfsr_q);
                        cnt_d  = cnt_q + 8'd1;
                        if (int'(cnt_q) + 1 == WARMUP) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (found) begin
                        gnt_d   = N_REQ'(1) << sel;
                        rnd_d   = word;
                        valid_d = 1'b1;
                        lfsr_d  = lfsr_step(lfsr_q);
                        ptr_d   = PW'((int'(sel) + 1) % N_REQ);
                    end
                end
                default: state_d = ST_WARM;
            endcase
        end
    end

    always_ff @(posedge TRIG or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_WARM;
            lfsr_q  <= DEFAULT_SEED;
            cnt_q   <= 8'h00;
            ptr_q   <= '0;
            gnt_q   <= '0;
            rnd_q   <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            rnd_q   <= rnd_d;
            valid_q <= valid_d;
        end
    end

    assign GNT   = gnt_q;
    assign RND   = rnd_q;
    assign VALID = valid_q;
    assign READY = (state_q == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_rng_share_arbiter.sv
// ============================================================================
//  Module   : tb_rng_share_arbiter
//  Purpose  : Directed self-checking bench for rng_share_arbiter (WARMUP=2
//             main instance plus a WARMUP=0 instance on shared inputs).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rng_share_arbiter;

    logic       TRIG  = 1'b0;
    logic       RESET = 1'b0;
    logic       LOAD  = 1'b0;
    logic [7:0] SEED  = 8'h00;
    logic [3:0] REQ   = 4'b0000;

    logic [3:0] GNT, GNT0;
    logic [7:0] RND, RND0;
    logic       VALID, VALID0, READY, READY0;

    int errors = 0;
    int checks = 0;
    logic [7:0] m_s;

    rng_share_arbiter #(.N_REQ(4), .WARMUP(2), .DEFAULT_SEED(8'hA5)) u_dut (
        .TRIG(TRIG), .RESET(RESET), .LOAD(LOAD), .SEED(SEED), .REQ(REQ),
        .GNT(GNT), .RND(RND), .VALID(VALID), .READY(READY)
    );

    rng_share_arbiter #(.N_REQ(4), .WARMUP(0), .DEFAULT_SEED(8'hA5)) u_dut0 (
        .TRIG(TRIG), .RESET(RESET), .LOAD(LOAD), .SEED(SEED), .REQ(REQ),
        .GNT(GNT0), .RND(RND0), .VALID(VALID0), .READY(READY0)
    );

    always #5 TRIG = ~TRIG;

    function automatic logic [7:0] step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[3] ^ s[2] ^ s[1]};
    endfunction

    function automatic logic [7:0] word_for(input logic [7:0] s, input int i);
        logic [15:0] t;
`ifdef RNG_SHARE_DECORR_EN
        t = {s, s} << (i % 8);
        return t[15:8];
`else
        t = {8'h00, s};
        return t[7:0];
`endif
    endfunction

    task automatic tick();
        @(posedge TRIG);
        #1;
    endtask

    task automatic test_reset();
        #1 RESET = 1'b1;
        #1;
        checks++; if (GNT !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", GNT); end
        checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", VALID); end
        checks++; if (READY !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", READY); end
        checks++; if (RND !== 8'h00) begin errors++; $display("FAIL reset_rnd: got %h want 00", RND); end
        RESET = 1'b0;
    endtask

    task automatic test_load_warm();
        LOAD = 1'b1; SEED = 8'h01;
        tick();
        LOAD = 1'b0;
        checks++; if (READY !== 1'b0) begin errors++; $display("FAIL load_ready0: got %b want 0", READY); end
        tick();
        checks++; if (READY !== 1'b0) begin errors++; $display("FAIL warm1_ready: got %b want 0", READY); end
        checks++; if (GNT !== 4'b0000 || VALID !== 1'b0) begin errors++; $display("FAIL warm1_gnt: got %b/%b want 0000/0", GNT, VALID); end
        tick();
        checks++; if (READY !== 1'b1) begin errors++; $display("FAIL warm2_ready: got %b want 1", READY); end
        checks++; if (GNT !== 4'b0000 || VALID !== 1'b0) begin errors++; $display("FAIL warm2_gnt: got %b/%b want 0000/0", GNT, VALID); end
    endtask

    task automatic test_single_grant();
        REQ = 4'b0001;
        tick();
        REQ = 4'b0000;
        checks++; if (GNT !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", GNT); end
        checks++; if (RND !== 8'h05) begin errors++; $display("FAIL single_rnd: got %h want 05", RND); end
        checks++; if (VALID !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", VALID); end
        tick();
        checks++; if (GNT !== 4'b0000 || VALID !== 1'b0) begin errors++; $display("FAIL idle_gnt: got %b/%b want 0000/0", GNT, VALID); end
        REQ = 4'b0001;
        tick();
        REQ = 4'b0000;
        checks++; if (RND !== 8'h0B) begin errors++; $display("FAIL second_rnd: got %h want 0B", RND); end
        m_s = 8'h16;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        // Pointer is 1 here; a lone grant to requester 3 wraps it back to 0
        REQ = 4'b1000;
        tick();
        checks++; if (GNT !== 4'b1000 || RND !== word_for(8'h16, 3)) begin errors++; $display("FAIL rr_wrap: got %b/%h want 1000/%h", GNT, RND, word_for(8'h16, 3)); end
        m_s = step(m_s);
        REQ = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (GNT !== exp_g[k] || RND !== word_for(m_s, k % 4) || VALID !== 1'b1) begin
                errors++;
                $display("FAIL rr_%0d: got %b/%h/%b want %b/%h/1", k, GNT, RND, VALID, exp_g[k], word_for(m_s, k % 4));
            end
            m_s = step(m_s);
        end
        REQ = 4'b0000;
        tick();
    endtask

    task automatic test_load_zero_seed();
        REQ = 4'b1111; LOAD = 1'b1; SEED = 8'h00;
        tick();
        LOAD = 1'b0; REQ = 4'b0000;
        checks++; if (GNT !== 4'b0000 || VALID !== 1'b0 || READY !== 1'b0) begin errors++; $display("FAIL zseed_clear: got %b/%b/%b want 0000/0/0", GNT, VALID, READY); end
        tick();
        tick();
        REQ = 4'b0001;
        tick();
        REQ = 4'b0000;
        // A5 -> 4A -> 94 after two warm-up steps
        checks++; if (RND !== 8'h94 || GNT !== 4'b0001) begin errors++; $display("FAIL zseed_rnd: got %b/%h want 0001/94", GNT, RND); end
        tick();
    endtask

    task automatic test_load_mid_run();
        REQ = 4'b0010; LOAD = 1'b1; SEED = 8'h37;
        tick();
        LOAD = 1'b0;
        m_s = 8'h37;
        checks++; if (GNT !== 4'b0000 || READY !== 1'b0 || VALID !== 1'b0) begin errors++; $display("FAIL midload_clear: got %b/%b/%b want 0000/0/0", GNT, READY, VALID); end
        tick(); m_s = step(m_s);
        checks++; if (READY !== 1'b0 || GNT !== 4'b0000) begin errors++; $display("FAIL midload_warm: got %b/%b want 0/0000", READY, GNT); end
        tick(); m_s = step(m_s);
        checks++; if (READY !== 1'b1 || GNT !== 4'b0000) begin errors++; $display("FAIL midload_ready: got %b/%b want 1/0000", READY, GNT); end
        tick();
        REQ = 4'b0000;
        checks++; if (GNT !== 4'b0010 || RND !== word_for(m_s, 1)) begin errors++; $display("FAIL midload_resume: got %b/%h want 0010/%h", GNT, RND, word_for(m_s, 1)); end
        tick();
    endtask

    task automatic test_warmup_zero();
        LOAD = 1'b1; SEED = 8'h5A; REQ = 4'b0000;
        tick();
        LOAD = 1'b0; REQ = 4'b0001;
        checks++; if (READY0 !== 1'b0) begin errors++; $display("FAIL wz_load: got %b want 0", READY0); end
        tick();
        checks++; if (READY0 !== 1'b1 || GNT0 !== 4'b0000) begin errors++; $display("FAIL wz_ready: got %b/%b want 1/0000", READY0, GNT0); end
        tick();
        REQ = 4'b0000;
        checks++; if (GNT0 !== 4'b0001 || RND0 !== 8'h5A || VALID0 !== 1'b1) begin errors++; $display("FAIL wz_grant: got %b/%h/%b want 0001/5A/1", GNT0, RND0, VALID0); end
        tick();
    endtask

    task automatic test_period();
        logic [7:0] words [256];
        bit         seen  [256];
        int         dups;
        LOAD = 1'b1; SEED = 8'h01; REQ = 4'b0000;
        tick();
        LOAD = 1'b0;
        tick(); tick();
        m_s = 8'h05;
        REQ = 4'b0001;
        for (int k = 0; k < 256; k++) begin
            tick();
            words[k] = RND;
            checks++;
            if (RND !== m_s || VALID !== 1'b1) begin
                errors++;
                $display("FAIL period_%0d: got %h/%b want %h/1", k, RND, VALID, m_s);
            end
            m_s = step(m_s);
        end
        REQ = 4'b0000;
        dups = 0;
        for (int k = 0; k < 256; k++) seen[k] = 1'b0;
        for (int k = 0; k < 255; k++) begin
            if (seen[words[k]]) dups++;
            seen[words[k]] = 1'b1;
        end
        checks++; if (dups != 0) begin errors++; $display("FAIL period_distinct: got %0d repeats want 0", dups); end
        checks++; if (words[255] !== words[0] || words[0] !== 8'h05) begin errors++; $display("FAIL period_wrap: got %h/%h want 05/05", words[0], words[255]); end
        tick();
    endtask

    task automatic test_decorr_req3();
        LOAD = 1'b1; SEED = 8'h01; REQ = 4'b0000;
        tick();
        LOAD = 1'b0;
        tick(); tick();
        m_s = 8'h05;
        REQ = 4'b1000;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (GNT !== 4'b1000 || RND !== word_for(m_s, 3)) begin
                errors++;
                $display("FAIL req3_%0d: got %b/%h want 1000/%h", k, GNT, RND, word_for(m_s, 3));
            end
            m_s = step(m_s);
        end
        REQ = 4'b0000;
        tick();
    endtask

    task automatic test_async_reset_mid_grant();
        LOAD = 1'b1; SEED = 8'h01;
        tick();
        LOAD = 1'b0;
        tick(); tick();
        REQ = 4'b0001;
        tick();
        checks++; if (VALID !== 1'b1) begin errors++; $display("FAIL arst_pre: got %b want 1", VALID); end
        #2 RESET = 1'b1;
        #1;
        checks++; if (GNT !== 4'b0000 || VALID !== 1'b0 || READY !== 1'b0 || RND !== 8'h00) begin errors++; $display("FAIL arst_clear: got %b/%b/%b/%h want 0000/0/0/00", GNT, VALID, READY, RND); end
        RESET = 1'b0; REQ = 4'b0000;
        tick(); tick();
        REQ = 4'b0001;
        tick();
        REQ = 4'b0000;
        checks++; if (GNT !== 4'b0001 || RND !== 8'h94) begin errors++; $display("FAIL arst_reseed: got %b/%h want 0001/94", GNT, RND); end
        tick();
    endtask

    initial begin
        test_reset();
        test_load_warm();
        test_single_grant();
        test_round_robin();
        test_load_zero_seed();
        test_load_mid_run();
        test_warmup_zero();
        test_period();
        test_decorr_req3();
        test_async_reset_mid_grant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rng_share_arbiter.md
Name: rng_share_arbiter

Overview:
Owns one 8-bit maximal-length LFSR random source and shares it among N_REQ stochastic-number requesters using round-robin grants.
- Sequences seeding: load, then warm-up stepping, then serving words.
- The LFSR advances only when a word is consumed, so each word is issued to exactly one requester.
- Sits between the seed/configuration logic and the comparator-based stochastic number generators.

Parameters:
N_REQ, 4, number of requesters (2..8)
WARMUP, 16, LFSR steps after seeding before grants start (0..255)
DEFAULT_SEED, 8'hA5, seed used after RESET and substituted for a zero SEED

Ports:
TRIG  input  1  clock, rising edge
RESET  input  1  asynchronous reset, active-high
LOAD  input  1  reseed request, sampled on TRIG
SEED  input  8  seed value, sampled when LOAD=1
REQ  input  N_REQ  per-requester word request, level, held until granted
GNT  output  N_REQ  one-hot grant, registered, one cycle per word
RND  output  8  random word for the granted requester, valid with VALID
VALID  output  1  RND/GNT valid this cycle
READY  output  1  1 in RUN state

Behaviour:
- LFSR polynomial 1+x2+x3+x4+x8, Fibonacci form.
  - Step: s <= {s[6:0], s[7]^s[3]^s[2]^s[1]}.
  - State is never 0, because a zero SEED is replaced by DEFAULT_SEED.
- Reset (async):
  - s=DEFAULT_SEED, state=WARM, warm count=0, round-robin pointer=0.
  - GNT=0, RND=0, VALID=0, READY=0.
- States: WARM, RUN. There is no other state.
- LOAD has top priority, in any state. On the edge where LOAD=1:
  - s <= (SEED==0 ? DEFAULT_SEED : SEED), state <= WARM, count <= 0.
  - GNT, VALID and READY are cleared.
  - No word is issued that cycle.
- WARM:
  - Each edge: s steps and count increments.
  - When count reaches WARMUP, transition to RUN. READY=1 from that edge onward.
  - WARMUP=0: go to RUN on the edge after LOAD/RESET with no steps.
  - REQ is ignored in WARM; GNT=0 and VALID=0.
- RUN, each edge:
  - If REQ!=0: grant the first asserted requester searching from pointer upward, wrapping N_REQ-1 -> 0.
    - GNT <= one-hot(i), RND <= s (pre-step value), VALID <= 1.
    - s steps; pointer <= (i+1) mod N_REQ.
  - If REQ==0: GNT <= 0, VALID <= 0; s and pointer hold.
- Latency: REQ sampled at edge k -> GNT/RND/VALID visible after edge k, i.e. for cycle k+1. The requester must drop or keep REQ by edge k+1.
  - A REQ still high at edge k+1 counts as a new request.
  - Round-robin fairness prevents that requester monopolising the source.
- Fairness: with all REQ held high, each requester receives one word every N_REQ cycles, in index order starting at the pointer.
- Maximum one word per cycle, so VALID never stays high without a step.
- Period 255: successive issued words never repeat within 255 grants.
- RESET or LOAD mid-grant: the word in flight is discarded and GNT is cleared. Requesters re-request after READY.

Optional Feature:
- Macro RNG_SHARE_DECORR_EN.
- Defined: the word issued to requester i is rotated left by (i mod 8) bits before driving RND. This decorrelates stochastic streams derived from consecutive LFSR words. The LFSR sequence itself is unchanged.
- Undefined: RND = s unmodified for every requester.

Test Plan:
- RESET, WARMUP=2, LOAD with SEED=8'h01, REQ=0 -> s steps 01,02,05; READY=1 after the 2nd edge following LOAD; GNT=0 and VALID=0 throughout.
- After the above, REQ=4'b0001 for one cycle -> next cycle GNT=0001, RND=8'h05, VALID=1; the following grant delivers 8'h0B.
- REQ=4'b1111 held, pointer=0 -> GNT sequence 0001,0010,0100,1000,0001; RND consecutive LFSR values; VALID high every cycle.
- LOAD with SEED=8'h00 -> s=8'hA5, state WARM, READY=0, GNT cleared the same edge.
- LOAD asserted during RUN with REQ=4'b0010 -> no GNT that cycle, READY drops; after WARMUP edges READY=1 and GNT resumes.
- Run 255 grants on a single requester from seed 8'h01 -> all 255 RND values distinct, the 256th equals the first; repeat with RNG_SHARE_DECORR_EN and requester 3 -> RND = rotl3 of the undefined-macro values.
